// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//
// UART serial transmitter. Bytes arrive over a valid/ready handshake into a
// one-entry holding register and are serialised on tx as: start bit, 8 data
// bits LSB first, optional parity bit, then 1 or 2 stop bits. The holding
// register can be refilled while a frame is in flight, so consecutive bytes go
// out back to back with no idle gap.
//
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   tx_data[7:0]   byte to send
//   tx_valid       tx_data is valid
//   tx_ready       holding register empty (registered)
//   baud_divisor   clocks per bit, 0 treated as 1, latched at frame start
//   i_parity_type  00 none, 01 even, 10 odd, 11 mark; latched at frame start
//   i_stop_bits    0: one stop bit, 1: two stop bits; latched at frame start
//   tx             serial line, idle high, registered
//   tx_busy        a frame is in progress
//   tx_done        high during the final clock of the last stop bit
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int DATA_BITS = 8,
   parameter int CLK_FREQ  = 50000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [7:0]  tx_data,
   input  logic        tx_valid,
   output logic        tx_ready,
   input  logic [15:0] baud_divisor,
   input  logic [1:0]  i_parity_type,
   input  logic        i_stop_bits,
   output logic        tx,
   output logic        tx_busy,
   output logic        tx_done
);

   // The frame format is fixed at 8 data bits; CLK_FREQ only documents the
   // clock the divisor was computed for.
   if (DATA_BITS != 8 || CLK_FREQ <= 0) begin : g_param_check
      $error("uart_tx: unsupported parameter override");
   end

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   logic [2:0]  r_state;
   logic [7:0]  r_hold;
   logic        r_hold_full;
   logic        r_tx_ready;
   logic [7:0]  r_shift;
   logic [2:0]  r_bit_idx;
   logic [15:0] r_cnt;
   logic [15:0] r_div;
   logic        r_par_en;
   logic        r_par_bit;
   logic        r_stop2;
   logic        r_stop_second;
   logic        r_tx;

   logic        w_accept;
   logic        w_bit_end;
   logic        w_last_stop;
   logic        w_frame_end;
   logic        w_load;
   logic [15:0] w_div;
   logic        w_par_bit;

   assign w_accept    = tx_valid && r_tx_ready;
   assign w_bit_end   = (r_cnt == r_div - 16'd1);
   assign w_last_stop = r_stop_second || !r_stop2;
   assign w_frame_end = (r_state == S_STOP) && w_bit_end && w_last_stop;
   // A frame starts from IDLE as soon as a byte is held, or straight out of the
   // last stop bit when the next byte is already waiting.
   assign w_load      = r_hold_full && ((r_state == S_IDLE) || w_frame_end);
   assign w_div       = (baud_divisor == 16'd0) ? 16'd1 : baud_divisor;

   always_comb begin
      w_par_bit = 1'b1;
      case (i_parity_type)
         2'b01:   w_par_bit = ^r_hold;
         2'b10:   w_par_bit = ~^r_hold;
         default: w_par_bit = 1'b1;
      endcase
   end

   // Holding register. Acceptance and load never coincide: tx_ready is low
   // whenever the register is full, and a load needs it full.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold      <= 8'd0;
         r_hold_full <= 1'b0;
         r_tx_ready  <= 1'b1;
      end else if (w_accept) begin
         r_hold      <= tx_data;
         r_hold_full <= 1'b1;
         r_tx_ready  <= 1'b0;
      end else if (w_load) begin
         r_hold_full <= 1'b0;
         r_tx_ready  <= 1'b1;
      end
   end

   // Bit timer: counts 0..div-1 within each bit, held at 0 while idle so every
   // frame starts from a clean count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= 16'd0;
      end else if (r_state == S_IDLE || w_bit_end) begin
         r_cnt <= 16'd0;
      end else begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // Frame sequencer. The value for the next bit is registered onto tx at the
   // bit_end that leaves the current bit, so tx changes exactly on bit edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_shift       <= 8'd0;
         r_bit_idx     <= 3'd0;
         r_div         <= 16'd1;
         r_par_en      <= 1'b0;
         r_par_bit     <= 1'b0;
         r_stop2       <= 1'b0;
         r_stop_second <= 1'b0;
         r_tx          <= 1'b1;
      end else if (w_load) begin
         r_state       <= S_START;
         r_shift       <= r_hold;
         r_bit_idx     <= 3'd0;
         r_div         <= w_div;
         r_par_en      <= |i_parity_type;
         r_par_bit     <= w_par_bit;
         r_stop2       <= i_stop_bits;
         r_stop_second <= 1'b0;
         r_tx          <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_tx <= 1'b1;
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state   <= S_DATA;
                  r_bit_idx <= 3'd0;
                  r_tx      <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_idx == LAST_BIT) begin
                     r_stop_second <= 1'b0;
                     if (r_par_en) begin
                        r_state <= S_PARITY;
                        r_tx    <= r_par_bit;
                     end else begin
                        r_state <= S_STOP;
                        r_tx    <= 1'b1;
                     end
                  end else begin
                     r_shift   <= r_shift >> 1;
                     r_bit_idx <= r_bit_idx + 3'd1;
                     r_tx      <= r_shift[1];
                  end
               end
            end
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state       <= S_STOP;
                  r_stop_second <= 1'b0;
                  r_tx          <= 1'b1;
               end
            end
            S_STOP: begin
               if (w_bit_end) begin
                  if (!w_last_stop) begin
                     r_stop_second <= 1'b1;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
               r_tx <= 1'b1;
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign tx       = r_tx;
   assign tx_ready = r_tx_ready;
   assign tx_busy  = (r_state != S_IDLE);
   assign tx_done  = w_frame_end;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//
// Bench for uart_tx. A frame-level model predicts tx/tx_busy/tx_done/tx_ready
// every clock from the byte, divisor and format captured at frame start; a
// compare process checks the DUT against it on each falling edge. Directed
// tests additionally pin recorded waveforms against hand-written frames.
// -----------------------------------------------------------------------------
module tb_uart_tx;

   logic        clk;
   logic        rst_n;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [15:0] baud_divisor;
   logic [1:0]  i_parity_type;
   logic        i_stop_bits;
   logic        tx;
   logic        tx_busy;
   logic        tx_done;

   uart_tx #(.DATA_BITS(8), .CLK_FREQ(50000000)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .baud_divisor (baud_divisor),
      .i_parity_type(i_parity_type),
      .i_stop_bits  (i_stop_bits),
      .tx           (tx),
      .tx_busy      (tx_busy),
      .tx_done      (tx_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   // A frame is a list of line levels, one per bit; the level at clock t of
   // the frame is bits[t / div] and the frame lasts div * nbits clocks.
   bit         m_full   = 1'b0;
   logic [7:0] m_byte   = 8'd0;
   bit         m_active = 1'b0;
   bit         m_acc    = 1'b0;
   int         m_t      = 0;
   int         m_div    = 1;
   int         m_nb     = 0;
   int         m_len    = 0;
   bit         m_bits [0:11];

   task automatic model_start();
      m_active = 1'b1;
      m_t      = 0;
      m_div    = (baud_divisor == 16'd0) ? 1 : int'(baud_divisor);
      m_bits[0] = 1'b0;
      for (int i = 0; i < 8; i++) m_bits[1 + i] = m_byte[i];
      m_nb = 9;
      if (i_parity_type != 2'b00) begin
         if (i_parity_type == 2'b01)      m_bits[m_nb] = ^m_byte;
         else if (i_parity_type == 2'b10) m_bits[m_nb] = ~^m_byte;
         else                             m_bits[m_nb] = 1'b1;
         m_nb = m_nb + 1;
      end
      m_bits[m_nb] = 1'b1;
      m_nb = m_nb + 1;
      if (i_stop_bits) begin
         m_bits[m_nb] = 1'b1;
         m_nb = m_nb + 1;
      end
      m_len  = m_div * m_nb;
      m_full = 1'b0;
   endtask

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         m_full   = 1'b0;
         m_active = 1'b0;
         m_t      = 0;
      end else begin
         cyc++;
         m_acc = tx_valid && !m_full;
         if (m_active) begin
            if (m_t == m_len - 1) begin
               if (m_full) model_start();
               else        m_active = 1'b0;
            end else begin
               m_t++;
            end
         end else if (m_full) begin
            model_start();
         end
         if (m_acc) begin
            m_full = 1'b1;
            m_byte = tx_data;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         check("cyc_tx",    int'(tx),       m_active ? int'(m_bits[m_t / m_div]) : 1);
         check("cyc_busy",  int'(tx_busy),  int'(m_active));
         check("cyc_done",  int'(tx_done),  int'(m_active && (m_t == m_len - 1)));
         check("cyc_ready", int'(tx_ready), int'(!m_full));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- helpers
   bit s_tx   [0:127];
   bit s_done [0:127];
   bit s_busy [0:127];

   // Returns #1 after the acceptance edge; acc_cyc is that edge's number.
   task automatic send_byte(input logic [7:0] d, output int acc_cyc);
      bit was_free;
      int n;
      tx_valid = 1'b1;
      tx_data  = d;
      was_free = 1'b0;
      n = 0;
      while (!was_free && n < 2000) begin
         @(negedge clk);
         was_free = !m_full;
         @(posedge clk);
         #1;
         n++;
      end
      check("accept_in_time", int'(was_free), 1);
      acc_cyc = cyc;
   endtask

   // Sample k = value after the k-th edge following the call.
   task automatic record(input int n);
      for (int k = 1; k <= n; k++) begin
         @(posedge clk);
         #1;
         s_tx[k]   = tx;
         s_done[k] = tx_done;
         s_busy[k] = tx_busy;
      end
   endtask

   task automatic check_frame(input string name, input logic [11:0] bits,
                              input int nb, input int div, input int off);
      int ndone;
      for (int b = 0; b < nb; b++)
         for (int j = 0; j < div; j++)
            check(name, int'(s_tx[off + b * div + j + 1]), int'(bits[b]));
      ndone = 0;
      for (int k = off + 1; k <= off + nb * div; k++) ndone += int'(s_done[k]);
      check({name, "_done_cnt"}, ndone, 1);
      check({name, "_done_last"}, int'(s_done[off + nb * div]), 1);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((m_active || m_full) && n < 5000) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("idle_in_time", int'(m_active || m_full), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   // ---------------------------------------------------------------- tests
   int acc1, acc2, cnt_busy, zeros, busy_seen;

   initial begin
      rst_n         = 1'b1;
      tx_valid      = 1'b0;
      tx_data       = 8'd0;
      baud_divisor  = 16'd4;
      i_parity_type = 2'b00;
      i_stop_bits   = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx",    int'(tx),       1);
      check("rst_ready", int'(tx_ready), 1);
      check("rst_busy",  int'(tx_busy),  0);
      check("rst_done",  int'(tx_done),  0);
      @(negedge clk);
      rst_n  = 1'b1;
      cmp_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // 0xA5, div 4, no parity, one stop bit: 40-clock frame.
      send_byte(8'hA5, acc1);
      tx_valid = 1'b0;
      check("t1_tx_at_accept", int'(tx), 1);
      record(41);
      check("t1_start_edge", int'(s_tx[1]), 0);
      check_frame("t1", 12'b0011_0100_1010, 10, 4, 0);
      check("t1_idle_after", int'(s_busy[41]), 0);
      wait_idle();

      // Parity variants: even over 0xA5 -> 0, odd -> 1, mark over 0x00 -> 1.
      i_parity_type = 2'b01;
      send_byte(8'hA5, acc1);
      tx_valid = 1'b0;
      record(45);
      check_frame("t2_even", 12'b0101_0100_1010, 11, 4, 0);
      check("t2_even_idle", int'(s_busy[45]), 0);
      wait_idle();

      i_parity_type = 2'b10;
      send_byte(8'hA5, acc1);
      tx_valid = 1'b0;
      record(45);
      check_frame("t2_odd", 12'b0111_0100_1010, 11, 4, 0);
      wait_idle();

      i_parity_type = 2'b11;
      send_byte(8'h00, acc1);
      tx_valid = 1'b0;
      record(45);
      check_frame("t2_mark", 12'b0110_0000_0000, 11, 4, 0);
      wait_idle();

      // Back-to-back: div 3, two stop bits, tx_valid held across both bytes.
      i_parity_type = 2'b00;
      i_stop_bits   = 1'b1;
      baud_divisor  = 16'd3;
      send_byte(8'h0F, acc1);
      fork
         begin
            send_byte(8'hF0, acc2);
            tx_valid = 1'b0;
         end
         record(67);
      join
      check("t3_accept_gap", acc2 - acc1, 2);
      check_frame("t3_f1", 12'b0110_0001_1110, 11, 3, 0);
      check_frame("t3_f2", 12'b0111_1110_0000, 11, 3, 33);
      cnt_busy = 0;
      for (int k = 1; k <= 66; k++) cnt_busy += int'(s_busy[k]);
      check("t3_busy_span", cnt_busy, 66);
      check("t3_idle_after", int'(s_busy[67]), 0);
      wait_idle();

      // Divisor 0 acts as 1; a mid-frame divisor change is ignored.
      i_stop_bits  = 1'b0;
      baud_divisor = 16'd0;
      send_byte(8'h81, acc1);
      tx_valid = 1'b0;
      fork
         record(11);
         begin
            repeat (3) @(negedge clk);
            baud_divisor = 16'd8;
         end
      join
      check_frame("t4", 12'b0011_0000_0010, 10, 1, 0);
      check("t4_idle_after", int'(s_busy[11]), 0);
      wait_idle();

      // Reset during DATA with a second byte held: frame aborts, byte dropped.
      baud_divisor = 16'd4;
      send_byte(8'h55, acc1);
      send_byte(8'h33, acc2);
      tx_valid = 1'b0;
      repeat (10) @(posedge clk);
      #3;
      check("t5_busy_before", int'(tx_busy), 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_tx",    int'(tx),       1);
      check("t5_rst_busy",  int'(tx_busy),  0);
      check("t5_rst_ready", int'(tx_ready), 1);
      check("t5_rst_done",  int'(tx_done),  0);
      @(negedge clk);
      rst_n = 1'b1;
      zeros     = 0;
      busy_seen = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         zeros     += int'(tx == 1'b0);
         busy_seen += int'(tx_busy);
      end
      check("t5_no_residual_tx",   zeros,     0);
      check("t5_no_residual_busy", busy_seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
